// File: rtl/pixspi_rx_pkg.sv
// rtl/pixspi_rx_pkg.sv - shared constants and FSM state type for pixspi_rx (HDR state added under PIXSPI_HDR_EN)
package pixspi_rx_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int HDR_W       = 16;
    localparam int CNT_W       = 5;

`ifdef PIXSPI_HDR_EN
    typedef enum logic [1:0] {IDLE, SHIFT, HDR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    function automatic logic [CNT_W-1:0] cnt_last(input int bits);
        return CNT_W'(bits - 1);
    endfunction

endpackage

// File: rtl/pixspi_rx_if.sv
// rtl/pixspi_rx_if.sv - SPI pins plus framebuffer write port and frame status of pixspi_rx
interface pixspi_rx_if #(
    parameter int PIXEL_W = 32,
    parameter int ADDR_W  = 12
);
    logic                spi_clk;
    logic                spi_ss;
    logic                spi_mosi;
    logic [ADDR_W-1:0]   waddr;
    logic [PIXEL_W-1:0]  wdata;
    logic                we;
    logic                frame_done;
    logic [ADDR_W:0]     word_count;
    logic                overflow;

    modport master (
        output spi_clk, spi_ss, spi_mosi,
        input  waddr, wdata, we, frame_done, word_count, overflow
    );

    modport slave (
        input  spi_clk, spi_ss, spi_mosi,
        output waddr, wdata, we, frame_done, word_count, overflow
    );
endinterface

// File: rtl/pixspi_rx_sync_edge.sv
// rtl/pixspi_rx_sync_edge.sv - two-flop synchroniser with registered rise/fall detector
module spi_sync_edge
    import pixspi_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // level is taken after the detector flop so it lines up with rise/fall
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & last_q;
        end
    end

    assign level = last_q;
endmodule

// File: rtl/pixspi_rx.sv
// rtl/pixspi_rx.sv - SPI-slave pixel receiver writing words to framebuffer; PIXSPI_HDR_EN adds 16-bit start address header
module pixspi_rx
    import pixspi_rx_pkg::*;
#(
    parameter int PIXEL_W = 32,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4096,
    parameter int CPOL    = 0,
    parameter int CPHA    = 0
) (
    input  logic        sysclk,
    input  logic        rst,
    pixspi_rx_if.slave  bus
);
    localparam bit                SAMPLE_RISE = (CPOL == CPHA);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
`ifdef PIXSPI_HDR_EN
    localparam state_t            FIRST_STATE = HDR;
`else
    localparam state_t            FIRST_STATE = SHIFT;
`endif

    logic sck_rise, sck_fall, ss_rise, ss_fall, mosi, sample;
    logic sck_level_unused, ss_level_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge u_sck (.clk(sysclk), .rst(rst), .din(bus.spi_clk), .level(sck_level_unused),
                         .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge u_ss (.clk(sysclk), .rst(rst), .din(bus.spi_ss), .level(ss_level_unused),
                        .rise(ss_rise), .fall(ss_fall));
    spi_sync_edge u_mosi (.clk(sysclk), .rst(rst), .din(bus.spi_mosi), .level(mosi),
                          .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    assign sample = SAMPLE_RISE ? sck_rise : sck_fall;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bitcnt;
    logic [PIXEL_W-1:0] shreg, wdata;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W:0]    word_count;
    logic               we, frame_done, overflow, wrapped, word_rdy, done_pend;
`ifdef PIXSPI_HDR_EN
    logic [HDR_W-1:0]   hdr_sr, hdr_next;
    assign hdr_next = {hdr_sr[HDR_W-2:0], mosi};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = FIRST_STATE;
`ifdef PIXSPI_HDR_EN
            HDR:     if (ss_rise) state_d = IDLE;
                     else if (sample && bitcnt == cnt_last(HDR_W)) state_d = SHIFT;
`endif
            SHIFT:   if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            bitcnt     <= '0;
            shreg      <= '0;
            wdata      <= '0;
            waddr      <= '0;
            word_count <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            wrapped    <= 1'b0;
            word_rdy   <= 1'b0;
            done_pend  <= 1'b0;
`ifdef PIXSPI_HDR_EN
            hdr_sr     <= '0;
`endif
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            if (word_rdy) begin
                wdata    <= shreg;
                we       <= 1'b1;
                word_rdy <= 1'b0;
            end
            // Address moves only after the write pulse so waddr is stable during we
            if (we) begin
                if (wrapped) overflow <= 1'b1;
                if (waddr == LAST_ADDR) begin
                    waddr   <= '0;
                    wrapped <= 1'b1;
                end else begin
                    waddr <= waddr + 1'b1;
                end
                if (word_count != '1) word_count <= word_count + 1'b1;
            end
            // A word finished together with SS rise is written before frame_done
            if (done_pend && !word_rdy) begin
                frame_done <= 1'b1;
                done_pend  <= 1'b0;
            end
            case (state_q)
                IDLE: if (ss_fall) begin
                    waddr      <= '0;
                    bitcnt     <= '0;
                    word_count <= '0;
                    overflow   <= 1'b0;
                    wrapped    <= 1'b0;
                    done_pend  <= 1'b0;
                end
                SHIFT: if (sample) begin
                    shreg <= {shreg[PIXEL_W-2:0], mosi};
                    if (bitcnt == cnt_last(PIXEL_W)) begin
                        bitcnt   <= '0;
                        word_rdy <= 1'b1;
                    end else begin
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
`ifdef PIXSPI_HDR_EN
                HDR: if (sample) begin
                    hdr_sr <= hdr_next;
                    if (bitcnt == cnt_last(HDR_W)) begin
                        bitcnt <= '0;
                        if (32'(hdr_next) >= DEPTH) begin
                            waddr    <= '0;
                            overflow <= 1'b1;
                        end else begin
                            waddr <= hdr_next[ADDR_W-1:0];
                        end
                    end else begin
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
            if (state_q != IDLE && ss_rise) done_pend <= 1'b1;
        end
    end

    assign bus.waddr      = waddr;
    assign bus.wdata      = wdata;
    assign bus.we         = we;
    assign bus.frame_done = frame_done;
    assign bus.word_count = word_count;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_pixspi_rx.sv
// tb/tb_pixspi_rx.sv - scoreboard bench for pixspi_rx over all four SPI modes plus a DEPTH=4 build
`timescale 1ns/1ps
module tb_pixspi_rx;
    localparam int N = 5;
    localparam int Q = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss = 1'b1, mosi = 1'b0, act0 = 1'b0, act1 = 1'b0;
    always #5 clk = ~clk;

    pixspi_rx_if #(.PIXEL_W(32), .ADDR_W(12)) if_m0 ();
    pixspi_rx_if #(.PIXEL_W(32), .ADDR_W(12)) if_m1 ();
    pixspi_rx_if #(.PIXEL_W(32), .ADDR_W(12)) if_m2 ();
    pixspi_rx_if #(.PIXEL_W(32), .ADDR_W(12)) if_m3 ();
    pixspi_rx_if #(.PIXEL_W(32), .ADDR_W(2))  if_s ();

    // act0 pulses mid-bit (CPHA=0 timing), act1 pulses from bit start (CPHA=1 timing)
    assign if_m0.spi_clk = act0;   assign if_m0.spi_ss = ss;  assign if_m0.spi_mosi = mosi;
    assign if_m1.spi_clk = act1;   assign if_m1.spi_ss = ss;  assign if_m1.spi_mosi = mosi;
    assign if_m2.spi_clk = ~act0;  assign if_m2.spi_ss = ss;  assign if_m2.spi_mosi = mosi;
    assign if_m3.spi_clk = ~act1;  assign if_m3.spi_ss = ss;  assign if_m3.spi_mosi = mosi;
    assign if_s.spi_clk  = act0;   assign if_s.spi_ss  = ss;  assign if_s.spi_mosi  = mosi;

    pixspi_rx #(.PIXEL_W(32), .ADDR_W(12), .DEPTH(4096), .CPOL(0), .CPHA(0)) dut_m0 (.sysclk(clk), .rst(rst), .bus(if_m0.slave));
    pixspi_rx #(.PIXEL_W(32), .ADDR_W(12), .DEPTH(4096), .CPOL(0), .CPHA(1)) dut_m1 (.sysclk(clk), .rst(rst), .bus(if_m1.slave));
    pixspi_rx #(.PIXEL_W(32), .ADDR_W(12), .DEPTH(4096), .CPOL(1), .CPHA(0)) dut_m2 (.sysclk(clk), .rst(rst), .bus(if_m2.slave));
    pixspi_rx #(.PIXEL_W(32), .ADDR_W(12), .DEPTH(4096), .CPOL(1), .CPHA(1)) dut_m3 (.sysclk(clk), .rst(rst), .bus(if_m3.slave));
    pixspi_rx #(.PIXEL_W(32), .ADDR_W(2),  .DEPTH(4),    .CPOL(0), .CPHA(0)) dut_s  (.sysclk(clk), .rst(rst), .bus(if_s.slave));

    logic        we_v[N], fd_v[N], ovf_v[N];
    logic [31:0] wa_v[N], wd_v[N];
    logic [12:0] wc_v[N];
    assign we_v[0] = if_m0.we; assign fd_v[0] = if_m0.frame_done; assign ovf_v[0] = if_m0.overflow;
    assign wa_v[0] = 32'(if_m0.waddr); assign wd_v[0] = if_m0.wdata; assign wc_v[0] = 13'(if_m0.word_count);
    assign we_v[1] = if_m1.we; assign fd_v[1] = if_m1.frame_done; assign ovf_v[1] = if_m1.overflow;
    assign wa_v[1] = 32'(if_m1.waddr); assign wd_v[1] = if_m1.wdata; assign wc_v[1] = 13'(if_m1.word_count);
    assign we_v[2] = if_m2.we; assign fd_v[2] = if_m2.frame_done; assign ovf_v[2] = if_m2.overflow;
    assign wa_v[2] = 32'(if_m2.waddr); assign wd_v[2] = if_m2.wdata; assign wc_v[2] = 13'(if_m2.word_count);
    assign we_v[3] = if_m3.we; assign fd_v[3] = if_m3.frame_done; assign ovf_v[3] = if_m3.overflow;
    assign wa_v[3] = 32'(if_m3.waddr); assign wd_v[3] = if_m3.wdata; assign wc_v[3] = 13'(if_m3.word_count);
    assign we_v[4] = if_s.we;  assign fd_v[4] = if_s.frame_done;  assign ovf_v[4] = if_s.overflow;
    assign wa_v[4] = 32'(if_s.waddr);  assign wd_v[4] = if_s.wdata;  assign wc_v[4] = 13'(if_s.word_count);

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [12:0] cnt; logic ovf; } fr_t;
    wr_t exp_wr[N][$];
    fr_t exp_fr[N][$];
    int  tests = 0;
    int  fails = 0;
    bit  fbits[$];
    logic [31:0] wq[$];

    function automatic int depth_of(input int i); return (i == 4) ? 4 : 4096; endfunction
    function automatic int aw_of(input int i);    return (i == 4) ? 2 : 12;   endfunction
    function automatic bit cpha_of(input int i);  return (i == 1 || i == 3);  endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic int pend_count();
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_wr[i].size() + exp_fr[i].size();
        return s;
    endfunction

    // Reference: group the bits DUT i saw into header and whole words
    task automatic model(input int i, input int n);
        int pos, start, nw, d, smax;
        bit clamp;
        logic [31:0] w;
        logic [15:0] hdr;
        d = depth_of(i); smax = (1 << (aw_of(i) + 1)) - 1;
        pos = 0; start = 0; clamp = 1'b0; hdr = '0;
`ifdef PIXSPI_HDR_EN
        if (n >= 16) begin
            for (int b = 0; b < 16; b++) hdr = {hdr[14:0], fbits[b]};
            pos = 16;
            if (int'(hdr) >= d) clamp = 1'b1;
            else start = int'(hdr);
        end else begin
            pos = n;
        end
`endif
        nw = (n - pos) / 32;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int b = 0; b < 32; b++) w = {w[30:0], fbits[pos + 32*k + b]};
            exp_wr[i].push_back('{addr: 32'((start + k) % d), data: w});
        end
        exp_fr[i].push_back('{cnt: 13'((nw > smax) ? smax : nw), ovf: clamp || (start + nw > d)});
    endtask

    task automatic drive_bits(input bit cut);
        for (int b = 0; b < fbits.size(); b++) begin
            mosi = fbits[b]; act1 = 1'b1; repeat (Q) @(posedge clk);
            act0 = 1'b1;
            if (cut && b == fbits.size() - 1) ss = 1'b1;
            repeat (Q) @(posedge clk);
            act1 = 1'b0; repeat (Q) @(posedge clk);
            act0 = 1'b0; repeat (Q) @(posedge clk);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (pend_count() != 0 && t < 300) begin @(posedge clk); t++; end
        if (pend_count() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d expectations pending, required 0", pend_count());
            for (int i = 0; i < N; i++) begin exp_wr[i].delete(); exp_fr[i].delete(); end
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic send_frame(input logic [15:0] hdr, input int extra, input bit cut);
        fbits.delete();
`ifdef PIXSPI_HDR_EN
        for (int b = 15; b >= 0; b--) fbits.push_back(hdr[b]);
`endif
        foreach (wq[k]) for (int b = 31; b >= 0; b--) fbits.push_back(wq[k][b]);
        for (int b = 0; b < extra; b++) fbits.push_back(1'($urandom_range(0, 1)));
        if (fbits.size() == 0) cut = 1'b0;
        $display("frame hdr=%h words=%0d extra=%0d cut=%0d", hdr, wq.size(), extra, cut);
        for (int i = 0; i < N; i++) model(i, (cut && cpha_of(i)) ? fbits.size() - 1 : fbits.size());
        @(posedge clk); ss = 1'b0;
        repeat (4*Q) @(posedge clk);
        drive_bits(cut);
        repeat (Q) @(posedge clk); ss = 1'b1;
        drain();
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        repeat (n) wq.push_back($urandom());
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_dut%0d_addr_data", tag, i), {wa_v[i], wd_v[i]}, 64'd0);
            check($sformatf("%s_dut%0d_flags_count", tag, i), 64'({we_v[i], fd_v[i], ovf_v[i], wc_v[i]}), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (we_v[i] === 1'b1) begin
                    wr_t e;
                    if (exp_wr[i].size() == 0) begin
                        tests++; fails++;
                        $display("FAIL dut%0d_unexpected_write: addr %h data %h, required no write", i, wa_v[i], wd_v[i]);
                    end else begin
                        e = exp_wr[i].pop_front();
                        check($sformatf("dut%0d_waddr", i), 64'(wa_v[i]), 64'(e.addr));
                        check($sformatf("dut%0d_wdata", i), 64'(wd_v[i]), 64'(e.data));
                    end
                end
                if (fd_v[i] === 1'b1) begin
                    fr_t f;
                    if (exp_fr[i].size() == 0) begin
                        tests++; fails++;
                        $display("FAIL dut%0d_unexpected_frame_done: count %0d, required no pulse", i, wc_v[i]);
                    end else begin
                        f = exp_fr[i].pop_front();
                        check($sformatf("dut%0d_word_count", i), 64'(wc_v[i]), 64'(f.cnt));
                        check($sformatf("dut%0d_overflow", i), 64'(ovf_v[i]), 64'(f.ovf));
                    end
                end
            end
        end
    end

    initial begin
        repeat (4) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        wq = '{32'hDEADBEEF, 32'h01234567, 32'hFFFFFFFF};
        send_frame(16'h0100, 0, 1'b0);
        rand_words(1);
        send_frame(16'(($urandom() & 32'h0FFF)), 8, 1'b0);
        rand_words(6);
        send_frame(16'h0FFD, 0, 1'b0);
        wq = '{32'hA5A5A5A5};
        send_frame(16'hFFFF, 0, 1'b0);

        // Reset mid-word: 17 bits then reset, nothing may be written
        fbits.delete();
        for (int b = 0; b < 17; b++) fbits.push_back(1'($urandom_range(0, 1)));
        @(posedge clk); ss = 1'b0;
        repeat (4*Q) @(posedge clk);
        drive_bits(1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        ss = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_reset("midframe_reset");

        wq = '{32'h00000001};
        send_frame(16'h0000, 0, 1'b0);
        rand_words(9);
        send_frame(16'h0100, 0, 1'b0);
        wq.delete();
        send_frame(16'h0002, 5, 1'b0);
        rand_words(2);
        send_frame(16'h0010, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            rand_words($urandom_range(0, 4));
            send_frame(16'($urandom()), $urandom_range(0, 40), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < N; i++) begin
            check($sformatf("dut%0d_leftover_writes", i), 64'(exp_wr[i].size()), 64'd0);
            check($sformatf("dut%0d_leftover_frames", i), 64'(exp_fr[i].size()), 64'd0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
